// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states,
// opcodes and datapath select codes.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_FAULT  = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // States that wait on the memory ready handshake
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mips_mem_wait_timer.sv
// Counts consecutive not-ready cycles in a memory state and flags a
// timeout when the count has reached MAX_WAIT and memory is still not ready.
module mips_mem_wait_timer #(
    parameter int MAX_WAIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic ready,
    output logic timeout
);
    localparam int W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    logic [W-1:0] cnt;

    generate
        if (MAX_WAIT > 0) begin : g_timeout
            assign timeout = active && !ready && (cnt == W'(MAX_WAIT));
        end else begin : g_no_timeout
            assign timeout = 1'b0;
        end
    endgenerate

    // Advance while stalled; any completion, state change or timeout restarts it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if ((MAX_WAIT > 0) && active && !ready && !timeout)
            cnt <= cnt + W'(1);
        else
            cnt <= '0;
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: sequences each instruction through 3-5
// states, stalls on memory ready, and locks into FAULT on memory timeout.
module mips_multicycle_control
    import mips_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MAX_WAIT    = 16,
    parameter int ENABLE_ADDI = 1,
    parameter int ENABLE_BNE  = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [5:0]       Opcode,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             PCEn,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSrc,
    output logic             IllegalOp,
    output logic             Fault,
    output logic [3:0]       State,
    output logic [CNT_W-1:0] InstrCount
);
    state_t           state, state_nxt;
    logic [5:0]       op_q;
    logic             fault_q;
    logic [CNT_W-1:0] cnt_q;
    logic             timeout;

    logic       pcen_d, iord_d, memread_d, memwrite_d, irwrite_d;
    logic       memtoreg_d, regdst_d, regwrite_d, srca_d, illegal_d;
    logic [1:0] srcb_d, aluop_d, pcsrc_d;

    mips_mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
        .clk     (CLK),
        .rst_n   (RESET),
        .active  (is_mem_state(state)),
        .ready   (MemReady),
        .timeout (timeout)
    );

    // State register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= S_FETCH;
        else        state <= state_nxt;
    end

    // Opcode captured in DECODE so later states ignore IR changes
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)                  op_q <= '0;
        else if (state == S_DECODE)  op_q <= Opcode;
    end

    // Sticky timeout flag, cleared only by reset
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)       fault_q <= 1'b0;
        else if (timeout) fault_q <= 1'b1;
    end

    // Retired-fetch counter, bumps on each completed instruction fetch
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)                           cnt_q <= '0;
        else if (state == S_FETCH && MemReady) cnt_q <= cnt_q + CNT_W'(1);
    end

    // Next-state and datapath control decode
    always_comb begin
        state_nxt  = state;
        pcen_d     = 1'b0;
        iord_d     = 1'b0;
        memread_d  = 1'b0;
        memwrite_d = 1'b0;
        irwrite_d  = 1'b0;
        memtoreg_d = 1'b0;
        regdst_d   = 1'b0;
        regwrite_d = 1'b0;
        srca_d     = 1'b0;
        illegal_d  = 1'b0;
        srcb_d     = SRCB_RT;
        aluop_d    = ALUOP_ADD;
        pcsrc_d    = PCSRC_ALU;
        case (state)
            S_FETCH: begin
                memread_d = 1'b1;
                srcb_d    = SRCB_FOUR;
                irwrite_d = MemReady;
                pcen_d    = MemReady;
                if (timeout)       state_nxt = S_FAULT;
                else if (MemReady) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                srcb_d = SRCB_IMM_SH2;
                if (Opcode == OP_LW || Opcode == OP_SW)
                    state_nxt = S_MEMADR;
                else if (Opcode == OP_RTYPE)
                    state_nxt = S_EXEC;
                else if (Opcode == OP_BEQ || (ENABLE_BNE != 0 && Opcode == OP_BNE))
                    state_nxt = S_BRANCH;
                else if (Opcode == OP_J)
                    state_nxt = S_JUMP;
                else if (ENABLE_ADDI != 0 && Opcode == OP_ADDI)
                    state_nxt = S_ADDIEX;
                else begin
                    illegal_d = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_MEMADR: begin
                srca_d    = 1'b1;
                srcb_d    = SRCB_IMM;
                state_nxt = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                memread_d = 1'b1;
                iord_d    = 1'b1;
                if (timeout)       state_nxt = S_FAULT;
                else if (MemReady) state_nxt = S_MEMWB;
            end
            S_MEMWB: begin
                regwrite_d = 1'b1;
                memtoreg_d = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_MEMWR: begin
                memwrite_d = 1'b1;
                iord_d     = 1'b1;
                if (timeout)       state_nxt = S_FAULT;
                else if (MemReady) state_nxt = S_FETCH;
            end
            S_EXEC: begin
                srca_d    = 1'b1;
                aluop_d   = ALUOP_FUNCT;
                state_nxt = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite_d = 1'b1;
                regdst_d   = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_BRANCH: begin
                srca_d    = 1'b1;
                aluop_d   = ALUOP_SUB;
                pcsrc_d   = PCSRC_ALUOUT;
                pcen_d    = (op_q == OP_BNE) ? ~Zero : Zero;
                state_nxt = S_FETCH;
            end
            S_JUMP: begin
                pcsrc_d   = PCSRC_JUMP;
                pcen_d    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_ADDIEX: begin
                srca_d    = 1'b1;
                srcb_d    = SRCB_IMM;
                state_nxt = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite_d = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_FAULT:  state_nxt = S_FAULT;
            default:  state_nxt = S_FETCH;
        endcase
    end

    // Reset forces every strobe low immediately, even mid-instruction
    assign PCEn       = RESET & pcen_d;
    assign IorD       = RESET & iord_d;
    assign MemRead    = RESET & memread_d;
    assign MemWrite   = RESET & memwrite_d;
    assign IRWrite    = RESET & irwrite_d;
    assign MemtoReg   = RESET & memtoreg_d;
    assign RegDst     = RESET & regdst_d;
    assign RegWrite   = RESET & regwrite_d;
    assign ALUSrcA    = RESET & srca_d;
    assign ALUSrcB    = {2{RESET}} & srcb_d;
    assign ALUOp      = {2{RESET}} & aluop_d;
    assign PCSrc      = {2{RESET}} & pcsrc_d;
    assign IllegalOp  = RESET & illegal_d;
    assign Fault      = fault_q;
    assign State      = state;
    assign InstrCount = cnt_q;

endmodule
